uart_tx_fifo_ctrl: RTL and testbench
====================================

# uart_tx_fifo_ctrl

Memory-mapped UART transmitter that serializes bytes written by the singlecycle core onto a board TX pin through an 8N1 frame. It is the output-direction counterpart of the debounced board-input path: the core pushes bytes, the block buffers them in a small FIFO and shifts them out at a fixed baud rate. It sits beside the LED/HEX output registers in the I/O region and its TX line is routed from the TOP level to a GPIO pin.

## Interface
- CLK_FREQ_HZ, 50_000_000, input clock frequency
- BAUD, 115200, line rate; DIV = CLK_FREQ_HZ / BAUD, integer truncation (434 at the default values), minimum 2
- FIFO_DEPTH, 8, byte entries, power of two, minimum 2
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_wr_en  in  1  write strobe from the core's store to the TX data address
- i_wr_data  in  8  byte to transmit
- o_full  out  1  FIFO holds FIFO_DEPTH entries
- o_busy  out  1  the FSM is not IDLE, or the FIFO is not empty
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_tx  out  1  serial line, idle high

## Operation
- A write is accepted when i_wr_en=1 and o_full=0 at the clock edge. A write while o_full=1 is dropped silently and leaves the FIFO unchanged.
- o_full is evaluated from the occupancy before the edge. A write arriving while full is rejected even if a pop happens in the same cycle.
- When a push and a pop occur in the same cycle on a non-full FIFO, o_level is unchanged and the data order is preserved.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: o_tx=1. If the FIFO is not empty, pop the head into the shift register, clear the baud counter and the bit index, and go to START.
  - START: o_tx=0 for DIV cycles, then go to DATA.
  - DATA: o_tx=shift[0]. Every DIV cycles, shift right and increment the bit index. After 8 bits, go to PARITY (if the feature is compiled in) or STOP. Bits are sent LSB first.
  - PARITY: o_tx=even parity (XOR of the 8 data bits) for DIV cycles, then go to STOP.
  - STOP: o_tx=1 for DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..DIV-1. The bit boundary is the cycle where the count equals DIV-1, and the counter wraps to 0 there.
- FIFO read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. o_level is a separate up/down counter.
- o_tx is registered (no combinational glitches on the pin).

## Timing
- Reset values: o_tx=1, o_full=0, o_busy=0, o_level=0, FSM=IDLE, FIFO pointers=0. Reset discards any data held in the FIFO.
- Reset asserted mid-frame: at the next edge o_tx=1, the frame is aborted and the FIFO is flushed.
- Latency: a write at edge N into an empty FIFO with the FSM in IDLE gives o_level=1 after N. The pop happens at edge N+1, and o_tx falls after N+1.
- o_busy rises after the write edge and falls after the edge that ends the final STOP bit with the FIFO empty.
- Frame length: 10*DIV cycles, or 11*DIV with parity.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present and one even-parity bit follows data bit 7 (8E1).
- Undefined: the PARITY state is compiled out and DATA goes directly to STOP (8N1).

## Structure
- Package uart_pkg holds the state typedef tx_state_e (IDLE, START, DATA, PARITY, STOP) and the constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- One sub-module, sync_fifo: parameterized width and depth, with push/pop/full/empty/level ports.
- The FSM, baud counter and shift register live in the top of this block.

## Test plan
- Bench parameters CLK_FREQ_HZ=10, BAUD=1 (DIV=10), parity off:
  - Write 0x55 -> o_tx=0 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then stop bit=1 for 10 cycles. o_busy drops after the 100th cycle of the frame.
  - 9 consecutive writes 0x00..0x08 while the first byte is still in the FIFO (write the first while the FSM is held in IDLE via a same-cycle check) -> o_full=1 at o_level=8. The 9th write is dropped, and exactly the bytes 0x00..0x07 appear on the line.
  - Two writes 0xA5 and 0x3C on back-to-back cycles -> the second start bit begins in the cycle immediately after the first stop bit's 10th cycle, with no idle-high gap.
  - Assert i_rst in the middle of data bit 3 of 0xF0 with 2 bytes still queued -> o_tx=1, o_level=0 and o_busy=0 after the next edge. No further frames follow.
- With UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1 and the frame is 110 cycles long. Write 0x03 -> parity bit=0.
- Push and pop in the same cycle (write during the STOP-end pop with o_level=3) -> o_level stays at 3 and the bytes are sent in FIFO order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Full is judged on the pre-edge occupancy, so a concurrent pop never rescues a write.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit after data bit 7 (8E1).
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_data,
  output logic                        o_full,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_tx
);
  localparam int DIV = (CLK_FREQ_HZ / BAUD < 2) ? 2 : CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(UART_DATA_BITS);

  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          fifo_pop, fifo_empty, bit_end;
  logic [7:0]    fifo_data;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst),
    .push(i_wr_en), .push_data(i_wr_data),
    .pop(fifo_pop), .pop_data(fifo_data),
    .full(o_full), .empty(fifo_empty), .level(o_level)
  );

  assign bit_end = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          bit_d    = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_data;
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(UART_DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        // Back-to-back frames: reload straight into START with no idle bit.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          bit_d    = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin level is derived from the next state so the registered output lines up with it.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START:   tx_d = ~UART_IDLE_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl at DIV=10; parity cases run when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_ctrl;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NSEG = 11;
`else
  localparam int NSEG = 10;
`endif
  localparam int FL = NSEG * DIV;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_full, o_busy, o_tx;
  logic [3:0] o_level;
  int         n_chk = 0;
  int         n_err = 0;

  uart_tx_fifo_ctrl #(.CLK_FREQ_HZ(10), .BAUD(1), .FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_full(o_full), .o_busy(o_busy), .o_level(o_level), .o_tx(o_tx)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    i_wr_en   = 1'b1;
    i_wr_data = b;
    tick();
    i_wr_en   = 1'b0;
  endtask

  // Called in the first START cycle of a frame; returns in the cycle after its stop bit.
  task automatic expect_frame(input logic [7:0] b);
    logic [NSEG-1:0] seg;
    seg[0] = 1'b0;
    for (int i = 0; i < 8; i++) seg[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    seg[9] = ^b;
`endif
    seg[NSEG-1] = 1'b1;
    for (int s = 0; s < NSEG; s++)
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("tx_%02h_s%0d_c%0d", b, s, c), o_tx, seg[s]);
        if (s == NSEG - 1 && c == DIV - 1) chk("busy_last_stop", o_busy, 1);
        tick();
      end
  endtask

  initial begin
    int lows;
    repeat (3) tick();
    i_rst = 1'b0;
    chk("rst_tx", o_tx, 1);
    chk("rst_full", o_full, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_level", o_level, 0);

    // Single byte 0x55
    wr(8'h55);
    chk("wr_level", o_level, 1);
    chk("wr_busy", o_busy, 1);
    chk("wr_tx_still_idle", o_tx, 1);
    tick();
    chk("pop_level", o_level, 0);
    expect_frame(8'h55);
    chk("55_busy_end", o_busy, 0);
    chk("55_tx_end", o_tx, 1);

    // Fill to full behind a frame in flight; the ninth write must be dropped
    wr(8'hFF);
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        chk("full_flag", o_full, 1);
        chk("full_level", o_level, 8);
      end
      i_wr_en   = 1'b1;
      i_wr_data = 8'(k);
      tick();
    end
    i_wr_en = 1'b0;
    chk("drop_level", o_level, 8);
    chk("drop_full", o_full, 1);
    repeat (FL - 9) tick();
    chk("after_ff_level", o_level, 7);
    for (int k = 0; k < 8; k++) expect_frame(8'(k));
    chk("fill_busy_end", o_busy, 0);
    chk("fill_level_end", o_level, 0);

    // Back-to-back writes, no idle gap between frames
    wr(8'hA5);
    wr(8'h3C);
    chk("b2b_level", o_level, 1);
    expect_frame(8'hA5);
    expect_frame(8'h3C);
    chk("b2b_busy_end", o_busy, 0);

    // Reset during data bit 3 of 0xF0 with two bytes queued
    wr(8'hF0);
    wr(8'h11);
    wr(8'h22);
    repeat (43) tick();
    chk("mid_bit3_tx", o_tx, 0);
    chk("mid_level", o_level, 2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_tx", o_tx, 1);
    chk("abort_level", o_level, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_full", o_full, 0);
    lows = 0;
    for (int c = 0; c < 50; c++) begin
      if (o_tx !== 1'b1 || o_busy !== 1'b0) lows++;
      tick();
    end
    chk("abort_quiet", lows, 0);

    // Simultaneous push and pop at the STOP-end reload
    wr(8'hB0);
    wr(8'hB1);
    wr(8'hB2);
    wr(8'hB3);
    repeat (FL - 3) tick();
    chk("pp_level_before", o_level, 3);
    wr(8'hB4);
    chk("pp_level_after", o_level, 3);
    expect_frame(8'hB1);
    expect_frame(8'hB2);
    expect_frame(8'hB3);
    expect_frame(8'hB4);
    chk("pp_busy_end", o_busy, 0);

`ifdef UART_TX_PARITY_EN
    wr(8'h07);
    tick();
    expect_frame(8'h07);
    chk("par07_busy_end", o_busy, 0);
    wr(8'h03);
    tick();
    expect_frame(8'h03);
    chk("par03_busy_end", o_busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
